// File: rtl/rdma_ctyun_sdpram_fifo.sv
// Valid/ready FIFO built on one rdma_ctyun_sdpram, with a prefetch buffer for first-word-fall-through output.
// Optional macro RDMA_FIFO_WATERMARK_EN adds the almost_full output and a stalled-push assertion.

module rdma_ctyun_sdpram #(
    parameter int    ADDR_WIDTH        = 8,
    parameter int    DATA_WIDTH        = 32,
    parameter int    READ_LATENCY      = 2,
    parameter string RAM_TYPE          = "AUTO",
    parameter string READ_DURING_WRITE = "DONT_CARE",
    localparam int   BE_WIDTH          = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clock,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [BE_WIDTH-1:0]   byteena,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("rdma_ctyun_sdpram: READ_LATENCY must be 1 or 2");
    end
    if (RAM_TYPE != "AUTO" && RAM_TYPE != "BLOCK" && RAM_TYPE != "DISTRIBUTED") begin : g_bad_type
        $error("rdma_ctyun_sdpram: unsupported RAM_TYPE");
    end
    if (READ_DURING_WRITE != "DONT_CARE") begin : g_bad_rdw
        $error("rdma_ctyun_sdpram: only DONT_CARE read-during-write is supported");
    end

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // NOTE: the storage array has no reset so it maps onto RAM primitives; its contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (wren) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (byteena[i/8]) mem[wraddress][i] <= data[i];
            end
        end
        if (rden) rd_q <= mem[rdaddress];
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q_reg;
        always_ff @(posedge clock) q_reg <= rd_q;
        assign q = q_reg;
    end else begin : g_lat1
        assign q = rd_q;
    end

endmodule

module rdma_ctyun_sdpram_fifo #(
    parameter int    ADDR_WIDTH     = 8,
    parameter int    DATA_WIDTH     = 32,
    parameter int    READ_LATENCY   = 2,
    parameter string RAM_TYPE       = "AUTO",
    parameter int    ALMOST_FULL_TH = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] usedw
`ifdef RDMA_FIFO_WATERMARK_EN
   ,output logic                  almost_full
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PF    = READ_LATENCY + 1;
    localparam int CNT_W = ADDR_WIDTH + 2;
    localparam int PF_IW = $clog2(PF);
    localparam int BE_W  = (DATA_WIDTH + 7) / 8;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PF_C    = CNT_W'(PF);

    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH + PF) begin : g_bad_th
        $error("rdma_ctyun_sdpram_fifo: ALMOST_FULL_TH outside 1..capacity");
    end

    logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        ram_cnt, ram_cnt_next;
    logic [CNT_W-1:0]        pf_cnt, inflight_cnt, usedw_next;
    logic [READ_LATENCY-1:0] inflight;
    logic [DATA_WIDTH-1:0]   pf_mem [PF];
    logic [PF_IW-1:0]        pf_wr_idx, pf_rd_idx;
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    push, pop, rd_issue, ret;

    function automatic logic [PF_IW-1:0] pf_next(input logic [PF_IW-1:0] idx);
        return (idx == PF_IW'(PF - 1)) ? '0 : idx + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        push         = in_valid && in_ready;
        pop          = out_valid && out_ready;
        ret          = inflight[READ_LATENCY-1];
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(inflight[i]);
        end
        // A pop this cycle frees a prefetch slot in time for the returning word.
        rd_issue     = (ram_cnt != '0) && ((pf_cnt + inflight_cnt - CNT_W'(pop)) < PF_C);
        ram_cnt_next = ram_cnt + CNT_W'(push) - CNT_W'(rd_issue);
        usedw_next   = usedw + CNT_W'(push) - CNT_W'(pop);
    end

    assign out_valid = (pf_cnt != '0);
    assign out_data  = pf_mem[pf_rd_idx];

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            pf_cnt    <= '0;
            inflight  <= '0;
            pf_wr_idx <= '0;
            pf_rd_idx <= '0;
            in_ready  <= 1'b0;
            usedw     <= '0;
            for (int i = 0; i < PF; i++) pf_mem[i] <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
            ram_cnt  <= ram_cnt_next;
            in_ready <= (ram_cnt_next < DEPTH_C);
            usedw    <= usedw_next;

            inflight[0] <= rd_issue;
            for (int i = 1; i < READ_LATENCY; i++) inflight[i] <= inflight[i-1];

            if (ret) begin
                pf_mem[pf_wr_idx] <= ram_q;
                pf_wr_idx         <= pf_next(pf_wr_idx);
            end
            if (pop) pf_rd_idx <= pf_next(pf_rd_idx);
            pf_cnt <= pf_cnt + CNT_W'(ret) - CNT_W'(pop);
        end
    end

    rdma_ctyun_sdpram #(
        .ADDR_WIDTH        (ADDR_WIDTH),
        .DATA_WIDTH        (DATA_WIDTH),
        .READ_LATENCY      (READ_LATENCY),
        .RAM_TYPE          (RAM_TYPE),
        .READ_DURING_WRITE ("DONT_CARE")
    ) u_ram (
        .clock     (clock),
        .wren      (push),
        .wraddress (wr_ptr),
        .data      (in_data),
        .byteena   ({BE_W{1'b1}}),
        .rden      (rd_issue),
        .rdaddress (rd_ptr),
        .q         (ram_q)
    );

`ifdef RDMA_FIFO_WATERMARK_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            almost_full <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            almost_full <= (usedw_next >= CNT_W'(ALMOST_FULL_TH));
            if (in_valid && !in_ready) begin
                if (stall_cnt <= DEPTH_C) stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    a_push_stall: assert property (@(posedge clock) disable iff (reset) stall_cnt <= DEPTH_C);
`endif

endmodule

// File: tb/tb_rdma_ctyun_sdpram_fifo.sv
// Bench for rdma_ctyun_sdpram_fifo: READ_LATENCY=2 and =1 instances share stimulus, each with its own scoreboard.
module tb_rdma_ctyun_sdpram_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, out_ready;
    logic [31:0] in_data;

    logic        in_ready2, out_valid2, in_ready1, out_valid1;
    logic [31:0] out_data2, out_data1;
    logic [5:0]  usedw2, usedw1;
`ifdef RDMA_FIFO_WATERMARK_EN
    logic        almost_full2, almost_full1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    rdma_ctyun_sdpram_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2),
                             .RAM_TYPE("AUTO"), .ALMOST_FULL_TH(12)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .usedw(usedw2)
`ifdef RDMA_FIFO_WATERMARK_EN
       ,.almost_full(almost_full2)
`endif
    );

    rdma_ctyun_sdpram_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1),
                             .RAM_TYPE("AUTO"), .ALMOST_FULL_TH(12)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .usedw(usedw1)
`ifdef RDMA_FIFO_WATERMARK_EN
       ,.almost_full(almost_full1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: capacity 19 for READ_LATENCY=2, 18 for READ_LATENCY=1.
    logic [31:0] q2[$], q1[$];
    int cnt2 = 0, cnt1 = 0, pops2 = 0;

    always @(negedge clock) begin
        if (reset) begin
            q2.delete(); q1.delete();
            cnt2 = 0; cnt1 = 0;
        end else begin
            check("usedw2_model", usedw2, cnt2);
            check("usedw1_model", usedw1, cnt1);
            if (cnt2 == 19) check("in_ready2_at_cap", in_ready2, 0);
            if (cnt1 == 18) check("in_ready1_at_cap", in_ready1, 0);
`ifdef RDMA_FIFO_WATERMARK_EN
            check("almost_full2", almost_full2, cnt2 >= 12);
            check("almost_full1", almost_full1, cnt1 >= 12);
`endif
            if (in_valid && in_ready2) begin q2.push_back(in_data); cnt2++; end
            if (in_valid && in_ready1) begin q1.push_back(in_data); cnt1++; end
            if (out_valid2 && out_ready) begin
                check("pop2_nonempty", q2.size() > 0, 1);
                if (q2.size() > 0) check("data2", out_data2, q2.pop_front());
                cnt2--; pops2++;
            end
            if (out_valid1 && out_ready) begin
                check("pop1_nonempty", q1.size() > 0, 1);
                if (q1.size() > 0) check("data1", out_data1, q1.pop_front());
                cnt1--;
            end
        end
    end

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [5:0]  e_uw;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int d, pushes, p0, uw_cnt;

        // Single word through an empty READ_LATENCY=2 FIFO: visible 3 edges after the accept edge.
        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 32'h0,          6'd0};
        vecs[1] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,          6'd1};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,          6'd1};
        vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,          6'd1};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hA5A5_0001,  6'd1};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,          6'd0};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready2", in_ready2, 0);
        check("rst_out_valid2", out_valid2, 0);
        check("rst_out_data2", out_data2, 0);
        check("rst_usedw2", usedw2, 0);
        check("rst_in_ready1", in_ready1, 0);
        check("rst_usedw1", usedw1, 0);
        @(posedge clock); #2 reset = 1'b0;
        @(posedge clock); #1;

        for (int r = 0; r < 6; r++) begin
            in_valid = vecs[r].iv; in_data = vecs[r].id; out_ready = vecs[r].ordy;
            @(negedge clock);
            check($sformatf("vec%0d_in_ready", r), in_ready2, vecs[r].e_ir);
            check($sformatf("vec%0d_out_valid", r), out_valid2, vecs[r].e_ov);
            check($sformatf("vec%0d_usedw", r), usedw2, vecs[r].e_uw);
            if (vecs[r].e_ov) check($sformatf("vec%0d_out_data", r), out_data2, vecs[r].e_od);
            @(posedge clock); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // Fill with the output stalled, then drain in order.
        d = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = 1'b1; in_data = d;
            @(negedge clock);
            if (in_ready2) d++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("fill_accepted2", d, 19);
        check("fill_usedw2", usedw2, 19);
        check("fill_in_ready2", in_ready2, 0);
        check("fill_usedw1", usedw1, 18);
        check("fill_in_ready1", in_ready1, 0);
        p0 = pops2;
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (25) @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        check("drain_pops2", pops2 - p0, 19);
        check("drain_usedw2", usedw2, 0);
        check("drain_out_valid2", out_valid2, 0);
        check("drain_usedw1", usedw1, 0);

        // Sustained push+pop every cycle: steady occupancy READ_LATENCY+2.
        @(posedge clock); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_data = 32'h1000 + c;
            @(negedge clock);
            if (c >= 10) begin
                check("tput_out_valid2", out_valid2, 1);
                check("tput_out_valid1", out_valid1, 1);
                check("tput_in_ready2", in_ready2, 1);
                check("tput_usedw2", usedw2, 4);
                check("tput_usedw1", usedw1, 3);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1 out_ready = 1'b0;

        // Random traffic.
        pushes = 0;
        for (int c = 0; c < 20000 && pushes < 2000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data = $urandom;
            @(negedge clock);
            if (in_valid && in_ready2) pushes++;
            @(posedge clock); #1;
        end
        check("rand_pushes_done", pushes >= 2000, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (30) @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        check("rand_drain_usedw2", usedw2, 0);
        check("rand_drain_usedw1", usedw1, 0);

        // Reset mid-stream with 10 words held.
        @(posedge clock); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h100 + i;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("pre_rst_usedw2", usedw2, 10);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid2", out_valid2, 0);
        check("mid_rst_usedw2", usedw2, 0);
        check("mid_rst_in_ready2", in_ready2, 0);
        check("mid_rst_out_valid1", out_valid1, 0);
        check("mid_rst_usedw1", usedw1, 0);
        @(posedge clock); #2 reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready_low", in_ready2, 0);
        @(posedge clock); #1;
        check("post_rst_in_ready_high", in_ready2, 1);
        in_valid = 1'b1; in_data = 32'h0000_BEEF;
        @(posedge clock); #1 in_valid = 1'b0;
        for (int c = 0; c < 10 && !out_valid2; c++) @(negedge clock);
        check("beef_out_valid2", out_valid2, 1);
        check("beef_out_data2", out_data2, 32'h0000_BEEF);
        check("beef_out_data1", out_data1, 32'h0000_BEEF);
        @(posedge clock); #1 out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        check("final_usedw2", usedw2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
